// File: rtl/present_inv_keyadd_sbox_serial.sv
// Serial PRESENT inverse key-addition + inverse S-box layer: out = InvSbox(state ^ key),
// processing NPAR nibbles per cycle behind valid/ready handshakes.
module present_inv_keyadd_sbox_serial #(
  parameter int WIDTH = 64,
  parameter int NPAR  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_state,
  input  logic [WIDTH-1:0] io_key,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_busy
);

  localparam int N  = WIDTH / (4 * NPAR);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_proc;
  logic [CW-1:0]    cnt_q;
  logic             last_chunk;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;
      4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;
      4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;
      4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;
      4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  assign last_chunk = (cnt_q == CW'(N - 1));

  // Only the nibbles of the current chunk are substituted; the rest pass through.
  always_comb begin
    data_proc = data_q;
    for (int i = 0; i < WIDTH / 4; i++) begin
      if (CW'(i / NPAR) == cnt_q) data_proc[4*i +: 4] = inv_sbox(data_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io_in_valid)  state_d = BUSY;
      BUSY:    if (last_chunk)   state_d = DONE;
      DONE:    if (io_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (io_in_valid) begin
          data_q <= io_state ^ io_key;
          cnt_q  <= '0;
        end
        BUSY: begin
          data_q <= data_proc;
          cnt_q  <= last_chunk ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_busy      = (state_q == BUSY);
  assign io_out_valid = (state_q == DONE);
  assign io_out       = data_q;

endmodule

// File: tb/tb_present_inv_keyadd_sbox_serial.sv
// Bench for present_inv_keyadd_sbox_serial: cycle-level transaction model plus directed
// literal checks at WIDTH=64 and WIDTH=8.
module tb_present_inv_keyadd_sbox_serial;

  localparam int N = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0, io_out_ready = 1'b0;
  logic        io_in_ready, io_out_valid, io_busy;
  logic [63:0] io_state = '0, io_key = '0, io_out;

  logic       v8_in_valid = 1'b0, v8_out_ready = 1'b0;
  logic       v8_in_ready, v8_out_valid, v8_busy;
  logic [7:0] v8_state = '0, v8_key = '0, v8_out;

  int n_checks = 0, n_fail = 0;

  present_inv_keyadd_sbox_serial #(.WIDTH(64), .NPAR(2)) dut (
    .clock(clock), .reset(reset), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_state(io_state), .io_key(io_key), .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready), .io_out(io_out), .io_busy(io_busy));

  present_inv_keyadd_sbox_serial #(.WIDTH(8), .NPAR(2)) dut8 (
    .clock(clock), .reset(reset), .io_in_valid(v8_in_valid), .io_in_ready(v8_in_ready),
    .io_state(v8_state), .io_key(v8_key), .io_out_valid(v8_out_valid),
    .io_out_ready(v8_out_ready), .io_out(v8_out), .io_busy(v8_busy));

  always #5 clock = ~clock;

  logic [3:0] inv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  logic [3:0] fwd_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] inv_layer(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] x, r;
    x = s ^ k;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_tab[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [7:0] fwd_layer8(input logic [7:0] s, input logic [7:0] k);
    logic [7:0] r;
    r[3:0] = fwd_tab[s[3:0]];
    r[7:4] = fwd_tab[s[7:4]];
    return r ^ k;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction model: tracks one pending operation and its age in cycles since acceptance.
  logic        synced = 1'b0, m_pend = 1'b0;
  int          m_age = 0, m_done = 0;
  logic [63:0] m_exp = '0;

  always @(negedge clock) begin
    if (synced) begin
      checkOutput("model in_ready",  64'(io_in_ready),  64'(!m_pend));
      checkOutput("model busy",      64'(io_busy),      64'(m_pend && m_age < N));
      checkOutput("model out_valid", 64'(io_out_valid), 64'(m_pend && m_age == N));
      if (m_pend && m_age == N) checkOutput("model out", io_out, m_exp);
    end
    if (reset) begin
      synced = 1'b1;
      m_pend = 1'b0;
      m_age  = 0;
    end else if (synced) begin
      if (!m_pend) begin
        if (io_in_valid) begin
          m_pend = 1'b1;
          m_age  = 0;
          m_exp  = inv_layer(io_state, io_key);
        end
      end else if (m_age < N) m_age++;
      else if (io_out_ready) begin
        m_pend = 1'b0;
        m_done++;
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] s, input logic [63:0] k);
    int t = 0;
    while (!io_in_ready && t < 100) begin @(posedge clock); #1; t++; end
    if (t >= 100) checkOutput("in_ready timeout", 64'(io_in_ready), 64'd1);
    io_state = s; io_key = k; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; the accepting edge counts as edge 1.
  task automatic waitResult(output int edges, output int busy_cycles);
    edges = 1; busy_cycles = 0;
    while (!io_out_valid && edges < 60) begin
      if (io_busy) busy_cycles++;
      @(posedge clock); #1; edges++;
    end
    if (!io_out_valid) checkOutput("out_valid timeout", 64'(io_out_valid), 64'd1);
  endtask

  task automatic consume();
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [63:0] s, input logic [63:0] k,
                             input logic [63:0] exp);
    int e, b;
    applyStimulus(s, k);
    waitResult(e, b);
    checkOutput({name, " latency"}, 64'(e), 64'(N + 1));
    checkOutput({name, " busy cycles"}, 64'(b), 64'(N));
    checkOutput({name, " value"}, io_out, exp);
    consume();
  endtask

  task automatic run8(input string name, input logic [7:0] s, input logic [7:0] k,
                      input logic [7:0] exp);
    int t = 0;
    v8_state = s; v8_key = k; v8_in_valid = 1'b1;
    @(posedge clock); #1;
    v8_in_valid = 1'b0;
    while (!v8_out_valid && t < 20) begin @(posedge clock); #1; t++; end
    checkOutput({name, " cycles"}, 64'(t), 64'd1);
    checkOutput({name, " value"}, 64'(v8_out), 64'(exp));
    v8_out_ready = 1'b1;
    @(posedge clock); #1;
    v8_out_ready = 1'b0;
  endtask

  logic [63:0] held;
  int          done_before, t;
  logic        rand_done = 1'b0;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset out", io_out, 64'h0);
    checkOutput("reset in_ready", 64'(io_in_ready), 64'd1);
    reset = 1'b0;

    runDirected("zero", 64'h0, 64'h0, 64'h5555555555555555);
    runDirected("table", 64'h0123456789ABCDEF, 64'h0, 64'h5EF8C12DB463079A);
    runDirected("allkey", 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'hA970364BD21C8FE5);

    run8("w8 literal", 8'h6A, 8'h0F, 8'h21);
    run8("w8 roundtrip", fwd_layer8(8'h21, 8'h0F), 8'h0F, 8'h21);
    run8("w8 roundtrip2", fwd_layer8(8'hC7, 8'h3B), 8'h3B, 8'hC7);

    // Back-pressure: result must hold while new requests are ignored.
    begin
      int e, b;
      applyStimulus(64'hDEADBEEFCAFEF00D, 64'h1122334455667788);
      waitResult(e, b);
      held = io_out;
      for (int i = 0; i < 5; i++) begin
        io_state = $urandom(); io_key = {$urandom(), $urandom()};
        io_in_valid = (i % 2 == 0);
        @(posedge clock); #1;
        checkOutput("bp out held", io_out, held);
        checkOutput("bp in_ready", 64'(io_in_ready), 64'd0);
      end
      io_in_valid = 1'b0;
      consume();
      checkOutput("bp released valid", 64'(io_out_valid), 64'd0);
      checkOutput("bp released ready", 64'(io_in_ready), 64'd1);
    end

    // Reset on the fourth BUSY cycle discards the operation.
    applyStimulus(64'h0F0F0F0F0F0F0F0F, 64'h1234);
    repeat (3) begin @(posedge clock); #1; end
    checkOutput("pre-reset busy", 64'(io_busy), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("midreset out", io_out, 64'h0);
    checkOutput("midreset valid", 64'(io_out_valid), 64'd0);
    checkOutput("midreset ready", 64'(io_in_ready), 64'd1);
    checkOutput("midreset busy", 64'(io_busy), 64'd0);
    runDirected("after reset", 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'hA970364BD21C8FE5);

    // Random regression with gaps on both sides; the model checks every result.
    done_before = m_done;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()});
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          io_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    io_out_ready = 1'b1;
    t = 0;
    while (m_done - done_before < 1000 && t < 100) begin @(posedge clock); #1; t++; end
    io_out_ready = 1'b0;
    checkOutput("random completed", 64'(m_done - done_before), 64'd1000);

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
